// File: rtl/ocp_sram_slave.sv
// ocp_sram_slave: OCP slave endpoint that services reads and writes from an
// internal word-addressed SRAM, with a configurable number of wait states.
// Optional build macro OCP_SRAM_SLAVE_RANGE_CHECK_EN: addresses above the
// SRAM answer ERR instead of aliasing onto it.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BEN_WIDTH
`define BEN_WIDTH 4
`endif
`ifndef OCP_CMD_IDLE
`define OCP_CMD_IDLE  3'b000
`define OCP_CMD_WRITE 3'b001
`define OCP_CMD_READ  3'b010
`endif
`ifndef OCP_RESP_NULL
`define OCP_RESP_NULL 2'b00
`define OCP_RESP_DVA  2'b01
`define OCP_RESP_ERR  2'b11
`endif

module ocp_sram_slave #(
   parameter int ADDR_BITS   = 10,
   parameter int WAIT_STATES = 1
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic [`ADDR_WIDTH-1:0] i_MAddr,
   input  logic [2:0]             i_MCmd,
   input  logic [`DATA_WIDTH-1:0] i_MData,
   input  logic [`BEN_WIDTH-1:0]  i_MByteEn,
   output logic                   o_SCmdAccept,
   output logic [`DATA_WIDTH-1:0] o_SData,
   output logic [1:0]             o_SResp
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_WAIT = 3'b010,
      ST_RESP = 3'b100
   } state_t;

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   state_t                 state_q, state_d;
   logic [3:0]             cnt_q;
   logic [`ADDR_WIDTH-1:0] addr_q;
   logic [2:0]             cmd_q;
   logic [`DATA_WIDTH-1:0] data_q;
   logic [`BEN_WIDTH-1:0]  ben_q;

   logic [`DATA_WIDTH-1:0] mem [2**ADDR_BITS];

   // With zero wait states the RESP edge is the accept edge itself, so the
   // access must see the live inputs; otherwise it uses the latched command.
   logic                   use_in;
   logic                   cmd_valid;
   logic [`ADDR_WIDTH-1:0] eff_addr;
   logic [2:0]             eff_cmd;
   logic [`DATA_WIDTH-1:0] eff_data;
   logic [`BEN_WIDTH-1:0]  eff_ben;
   logic [ADDR_BITS-1:0]   word_idx;
   logic                   in_range;
   logic                   is_wr, is_rd;
   logic                   go_resp;
   logic                   mem_we;
   logic                   unused_addr_bits;

   assign cmd_valid = (i_MCmd != `OCP_CMD_IDLE);
   assign use_in    = (state_q == ST_IDLE);
   assign eff_addr  = use_in ? i_MAddr   : addr_q;
   assign eff_cmd   = use_in ? i_MCmd    : cmd_q;
   assign eff_data  = use_in ? i_MData   : data_q;
   assign eff_ben   = use_in ? i_MByteEn : ben_q;
   assign word_idx  = eff_addr[ADDR_BITS+1:2];
   assign is_wr     = (eff_cmd == `OCP_CMD_WRITE);
   assign is_rd     = (eff_cmd == `OCP_CMD_READ);
   assign go_resp   = (state_d == ST_RESP) && (state_q != ST_RESP);
   // The nrst term keeps a write from committing on an edge seen while reset is held.
   assign mem_we    = go_resp && is_wr && in_range && nrst;

`ifdef OCP_SRAM_SLAVE_RANGE_CHECK_EN
   assign in_range         = (eff_addr[`ADDR_WIDTH-1:ADDR_BITS+2] == '0);
   assign unused_addr_bits = ^eff_addr[1:0];
`else
   assign in_range         = 1'b1;
   assign unused_addr_bits = ^{eff_addr[`ADDR_WIDTH-1:ADDR_BITS+2], eff_addr[1:0]};
`endif

   // Next-state and accept decode; accept depends only on being idle.
   always_comb begin
      state_d      = state_q;
      o_SCmdAccept = 1'b0;
      case (state_q)
         ST_IDLE: begin
            o_SCmdAccept = 1'b1;
            if (cmd_valid) state_d = (WS != 4'd0) ? ST_WAIT : ST_RESP;
         end
         ST_WAIT: if (cnt_q == 4'd1) state_d = ST_RESP;
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State register and wait-state counter.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && cmd_valid) cnt_q <= WS;
         else if (state_q == ST_WAIT)         cnt_q <= cnt_q - 4'd1;
      end
   end

   // Capture the accepted command; held commands are ignored outside IDLE.
   always_ff @(posedge clk) begin
      if (state_q == ST_IDLE && cmd_valid) begin
         addr_q <= i_MAddr;
         cmd_q  <= i_MCmd;
         data_q <= i_MData;
         ben_q  <= i_MByteEn;
      end
   end

   // Byte-lane write into the SRAM on the edge that enters RESP.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < `BEN_WIDTH; i++) begin
            if (eff_ben[i]) mem[word_idx][8*i +: 8] <= eff_data[8*i +: 8];
         end
      end
   end

   // Response register: valid for the single RESP cycle, cleared otherwise.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         o_SResp <= `OCP_RESP_NULL;
         o_SData <= '0;
      end else if (go_resp) begin
         if ((is_wr || is_rd) && in_range) begin
            o_SResp <= `OCP_RESP_DVA;
            o_SData <= is_rd ? mem[word_idx] : '0;
         end else begin
            o_SResp <= `OCP_RESP_ERR;
            o_SData <= '0;
         end
      end else begin
         o_SResp <= `OCP_RESP_NULL;
         o_SData <= '0;
      end
   end

endmodule

// File: tb/tb_ocp_sram_slave.sv
// Bench for ocp_sram_slave: one instance with one wait state, one with none.
// Expected responses are queued when a command is accepted and compared
// when the response appears.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BEN_WIDTH
`define BEN_WIDTH 4
`endif
`ifndef OCP_CMD_IDLE
`define OCP_CMD_IDLE  3'b000
`define OCP_CMD_WRITE 3'b001
`define OCP_CMD_READ  3'b010
`endif
`ifndef OCP_RESP_NULL
`define OCP_RESP_NULL 2'b00
`define OCP_RESP_DVA  2'b01
`define OCP_RESP_ERR  2'b11
`endif

module tb_ocp_sram_slave;

   localparam logic [2:0] IDL = `OCP_CMD_IDLE;
   localparam logic [2:0] WR  = `OCP_CMD_WRITE;
   localparam logic [2:0] RD  = `OCP_CMD_READ;
   localparam logic [1:0] NUL = `OCP_RESP_NULL;
   localparam logic [1:0] DVA = `OCP_RESP_DVA;
   localparam logic [1:0] ERR = `OCP_RESP_ERR;

`ifdef OCP_SRAM_SLAVE_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   logic clk = 1'b0;
   logic nrst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Instance 1: one wait state
   logic [31:0] ma1, md1, sd1;
   logic [2:0]  mc1;
   logic [3:0]  mb1;
   logic        acc1;
   logic [1:0]  sr1;
   // Instance 0: zero wait states
   logic [31:0] ma0, md0, sd0;
   logic [2:0]  mc0;
   logic [3:0]  mb0;
   logic        acc0;
   logic [1:0]  sr0;

   ocp_sram_slave #(.ADDR_BITS(10), .WAIT_STATES(1)) dut1 (
      .clk(clk), .nrst(nrst), .i_MAddr(ma1), .i_MCmd(mc1), .i_MData(md1),
      .i_MByteEn(mb1), .o_SCmdAccept(acc1), .o_SData(sd1), .o_SResp(sr1));

   ocp_sram_slave #(.ADDR_BITS(10), .WAIT_STATES(0)) dut0 (
      .clk(clk), .nrst(nrst), .i_MAddr(ma0), .i_MCmd(mc0), .i_MData(md0),
      .i_MByteEn(mb0), .o_SCmdAccept(acc0), .o_SData(sd0), .o_SResp(sr0));

   typedef struct {
      logic [1:0]  resp;
      logic [31:0] data;
      int          due;
   } exp_t;

   typedef struct {
      logic [2:0]  cmd;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  ben;
      logic [1:0]  resp;
      logic [31:0] rdata;
   } vec_t;

   exp_t q0[$];
   exp_t q1[$];
   vec_t tbl[$];

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] need);
      n_cmp++;
      if (got !== need) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, got, need, cyc);
      end
   endtask

   function automatic logic get_acc(input int sel);
      return (sel != 0) ? acc1 : acc0;
   endfunction

   task automatic drive(input int sel, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b);
      if (sel != 0) begin mc1 = c; ma1 = a; md1 = d; mb1 = b; end
      else          begin mc0 = c; ma0 = a; md0 = d; mb0 = b; end
   endtask

   task automatic push(input int sel, input logic [1:0] r, input logic [31:0] d, input int due);
      exp_t e;
      e.resp = r; e.data = d; e.due = due;
      if (sel != 0) q1.push_back(e);
      else          q0.push_back(e);
   endtask

   task automatic add(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, input logic [1:0] r, input logic [31:0] rd);
      vec_t v;
      v.cmd = c; v.addr = a; v.data = d; v.ben = b; v.resp = r; v.rdata = rd;
      tbl.push_back(v);
   endtask

   // One complete transaction: drive, wait for accept, queue the expectation,
   // then confirm accept stays low through WAIT and RESP and returns after.
   task automatic xact(input int sel, input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       input logic [1:0] r, input logic [31:0] rd);
      int t;
      int ws;
      ws = (sel != 0) ? 1 : 0;
      @(negedge clk);
      drive(sel, c, a, d, b);
      t = 0;
      while (!get_acc(sel) && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         check("accept_timeout", 32'(t), 32'd0);
         drive(sel, IDL, 32'h0, 32'h0, 4'h0);
         return;
      end
      @(posedge clk);
      #1;
      // Response is due on the cycle that starts ws edges after the accept edge.
      push(sel, r, rd, cyc + ws);
      drive(sel, IDL, 32'h0, 32'h0, 4'h0);
      for (int k = 0; k <= ws; k++) begin
         @(negedge clk);
         check("accept_low_busy", 32'(get_acc(sel)), 32'd0);
      end
      @(negedge clk);
      check("accept_back_idle", 32'(get_acc(sel)), 32'd1);
   endtask

   // Response monitors: every non-NULL response must match the queue head.
   always @(negedge clk) begin
      exp_t e;
      if (sr1 != NUL) begin
         if (q1.size() == 0) check("unexpected_resp_ws1", 32'(sr1), 32'(NUL));
         else begin
            e = q1.pop_front();
            check("resp_ws1", 32'(sr1), 32'(e.resp));
            check("sdata_ws1", sd1, e.data);
            check("latency_ws1", 32'(cyc), 32'(e.due));
         end
      end else check("sdata_idle_ws1", sd1, 32'h0);
      if (sr0 != NUL) begin
         if (q0.size() == 0) check("unexpected_resp_ws0", 32'(sr0), 32'(NUL));
         else begin
            e = q0.pop_front();
            check("resp_ws0", 32'(sr0), 32'(e.resp));
            check("sdata_ws0", sd0, e.data);
            check("latency_ws0", 32'(cyc), 32'(e.due));
         end
      end else check("sdata_idle_ws0", sd0, 32'h0);
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
      $fatal(1);
   end

   initial begin
      nrst = 1'b0;
      drive(1, IDL, 32'h0, 32'h0, 4'h0);
      drive(0, IDL, 32'h0, 32'h0, 4'h0);

      add(WR, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, DVA, 32'h0);
      add(RD, 32'h0000_0010, 32'h0,         4'hF, DVA, 32'hDEAD_BEEF);
      add(WR, 32'h0000_000C, 32'hFFFF_FFFF, 4'hF, DVA, 32'h0);
      add(WR, 32'h0000_000C, 32'h1122_3344, 4'h5, DVA, 32'h0);
      add(RD, 32'h0000_000C, 32'h0,         4'h0, DVA, 32'hFF22_FF44);
      add(RD, 32'h0000_000F, 32'h0,         4'hF, DVA, 32'hFF22_FF44);
      add(WR, 32'h0000_0000, 32'hA5A5_0001, 4'hF, DVA, 32'h0);
      add(WR, 32'h0000_0004, 32'h0101_0101, 4'hF, DVA, 32'h0);
      add(RD, 32'h0010_0000, 32'h0,         4'hF, RC ? ERR : DVA, RC ? 32'h0 : 32'hA5A5_0001);
      add(WR, 32'h0010_0004, 32'h0BAD_0BAD, 4'hF, RC ? ERR : DVA, 32'h0);
      add(RD, 32'h0000_0004, 32'h0,         4'hF, DVA, RC ? 32'h0101_0101 : 32'h0BAD_0BAD);
      add(3'b011, 32'h0000_0010, 32'h1234_5678, 4'hF, ERR, 32'h0);
      add(3'b111, 32'h0000_0010, 32'h1234_5678, 4'hF, ERR, 32'h0);
      add(RD, 32'h0000_0010, 32'h0,         4'hF, DVA, 32'hDEAD_BEEF);
      add(WR, 32'h0000_0014, 32'h5555_5555, 4'hF, DVA, 32'h0);
      add(RD, 32'h0000_0014, 32'h0,         4'hF, DVA, 32'h5555_5555);

      // Reset and idle behaviour
      repeat (3) @(negedge clk);
      check("rst_accept", 32'(acc1), 32'd1);
      check("rst_resp", 32'(sr1), 32'(NUL));
      nrst = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("idle_accept_ws1", 32'(acc1), 32'd1);
         check("idle_resp_ws1", 32'(sr1), 32'(NUL));
         check("idle_accept_ws0", 32'(acc0), 32'd1);
         check("idle_resp_ws0", 32'(sr0), 32'(NUL));
      end

      // Table-driven transactions on the one-wait-state instance
      for (int i = 0; i < tbl.size(); i++)
         xact(1, tbl[i].cmd, tbl[i].addr, tbl[i].data, tbl[i].ben, tbl[i].resp, tbl[i].rdata);

      // Zero wait states: setup write, then a read held for 8 cycles.
      xact(0, WR, 32'h0000_0020, 32'hCAFE_F00D, 4'hF, DVA, 32'h0);
      xact(0, RD, 32'h0000_0020, 32'h0, 4'hF, DVA, 32'hCAFE_F00D);
      @(negedge clk);
      drive(0, RD, 32'h0000_0020, 32'h0, 4'hF);
      for (int k = 0; k < 8; k++) begin
         check("b2b_accept", 32'(acc0), (k % 2 == 0) ? 32'd1 : 32'd0);
         @(posedge clk);
         #1;
         if (k % 2 == 0) push(0, DVA, 32'hCAFE_F00D, cyc);
         @(negedge clk);
      end
      drive(0, IDL, 32'h0, 32'h0, 4'h0);
      repeat (2) @(negedge clk);

      // Reset during WAIT of a write to word 5: no response, old data kept.
      @(negedge clk);
      check("midrst_pre_accept", 32'(acc1), 32'd1);
      drive(1, WR, 32'h0000_0014, 32'h1234_5678, 4'hF);
      @(posedge clk);
      #1;
      drive(1, IDL, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      check("midrst_in_wait", 32'(acc1), 32'd0);
      nrst = 1'b0;
      #1;
      check("midrst_accept", 32'(acc1), 32'd1);
      check("midrst_resp", 32'(sr1), 32'(NUL));
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_idle_accept", 32'(acc1), 32'd1);
      xact(1, RD, 32'h0000_0014, 32'h0, 4'hF, DVA, 32'h5555_5555);

      repeat (4) @(negedge clk);
      check("queues_drained", 32'(q0.size() + q1.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ocp_sram_slave.md
# ocp_sram_slave

OCP slave endpoint that terminates one fabric port and services reads and writes from an internal word-addressed SRAM. It sits behind a fabric port's slave-side OCP interface. It produces the command-accept and response handshake that the fabric port's RUN/BWAIT/DWAIT sequence consumes. The number of wait states is configurable so the block also models slow peripherals for fabric testing.

## Interface

Parameters:
- ADDR_BITS, 10, word-address width; memory depth is 2^ADDR_BITS words of `DATA_WIDTH bits.
- WAIT_STATES, 1, extra cycles between command accept and response (0..15).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- nrst  input  1  reset, asynchronous, active-low.
- i_MAddr  input  `ADDR_WIDTH  byte address, already decoded by the fabric port.
- i_MCmd  input  3  OCP command (`OCP_CMD_IDLE / `OCP_CMD_WRITE / `OCP_CMD_READ).
- i_MData  input  `DATA_WIDTH  write data.
- i_MByteEn  input  `BEN_WIDTH  byte-lane enables for writes.
- o_SCmdAccept  output  1  command accepted this cycle.
- o_SData  output  `DATA_WIDTH  read data, valid only with a DVA response.
- o_SResp  output  2  `OCP_RESP_NULL / `OCP_RESP_DVA / `OCP_RESP_ERR.

## Operation

- FSM states: IDLE, WAIT, RESP (one-hot).
- IDLE: o_SCmdAccept = 1 combinationally. It does not depend on i_MCmd.
  - When i_MCmd != `OCP_CMD_IDLE on a rising edge, latch addr/cmd/data/ben.
  - Load the wait counter with WAIT_STATES.
  - Go to WAIT if WAIT_STATES > 0, otherwise go to RESP.
- WAIT: o_SCmdAccept = 0. Decrement the counter each cycle. At counter == 1, the next state is RESP.
- RESP: o_SCmdAccept = 0. Drive o_SResp for exactly one cycle, then return to IDLE.
- Memory access happens on the edge that enters RESP:
  - Word index = latched addr[ADDR_BITS+1:2]. addr[1:0] is ignored.
  - Write: only lanes with ben[i] = 1 are updated. o_SData = 0 and o_SResp = DVA in RESP.
  - Read: the full word is registered into o_SData, regardless of byte enables. o_SResp = DVA.
  - Any other non-idle command: no memory access, o_SData = 0, o_SResp = ERR.
- Outside RESP: o_SResp = NULL and o_SData = 0.
- A new command can be accepted no earlier than the cycle after RESP (back-to-back spacing of WAIT_STATES+2 cycles).
- Memory contents are not reset.

## Timing

- Reset values: state IDLE, o_SCmdAccept = 1, o_SResp = NULL, o_SData = 0, counter = 0.
- Accept at edge N implies the response is visible during cycle N+WAIT_STATES+1 and lasts exactly one cycle.
- i_MCmd held by the master while o_SCmdAccept = 0 is ignored; it is not latched twice.
- Reset asserted mid-transaction:
  - Immediate return to IDLE.
  - No response is issued.
  - An uncommitted write (before the RESP edge) is dropped.
- Write followed by a read to the same word returns the new data. The write commits before the read can be accepted.

## Configuration

- OCP_SRAM_SLAVE_RANGE_CHECK_EN defined:
  - If latched addr[`ADDR_WIDTH-1:ADDR_BITS+2] != 0, there is no memory access.
  - In RESP: o_SResp = ERR, o_SData = 0.
- Macro undefined:
  - Upper address bits are ignored and addresses alias modulo 2^(ADDR_BITS+2).
  - Every read/write gets DVA.

## Test plan

- Reset, then idle: o_SCmdAccept = 1, o_SResp = NULL, o_SData = 0 for 10 cycles.
- WAIT_STATES=1:
  - Stimulus: write 0xDEADBEEF to 0x10 with ben 4'b1111, then read 0x10.
  - Required: each response DVA arrives 2 cycles after accept; read returns 0xDEADBEEF; o_SCmdAccept low during WAIT and RESP.
- Partial write:
  - Stimulus: write 0x11223344 with ben 4'b0101 over 0xFFFFFFFF at word 3, then read.
  - Required: read returns 0xFF22FF44.
- WAIT_STATES=0:
  - Stimulus: back-to-back reads held asserted.
  - Required: DVA every 2nd cycle; command held during RESP is not double-accepted.
- Range check:
  - Stimulus: read from 0x00100000 with ADDR_BITS=10.
  - Required: with RANGE_CHECK_EN the response is ERR with SData=0; without it, the response is DVA with the contents of word 0.
- Reset mid-operation:
  - Stimulus: assert nrst during WAIT of a write to word 5.
  - Required: no response; a subsequent read of word 5 returns the old value.
